// File: rtl/agc.sv
// Automatic gain control: multiplies each sample by an adaptive gain, saturates the
// product to sfix39_En36 and steers the gain so |out| tracks REF_LEVEL.
module agc #(
    parameter logic [38:0] REF_LEVEL = 39'h10_0000_0000,
    parameter int unsigned MU_SHIFT  = 8,
    parameter logic [25:0] GAIN_INIT = 26'h100_0000,
    parameter logic [25:0] GAIN_MIN  = 26'h000_0000,
    parameter logic [25:0] GAIN_MAX  = 26'h3FF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [12:0] inp_agc,
    output logic [38:0] out_agc
);

    localparam int unsigned IN_W    = 13;
    localparam int unsigned GAIN_W  = 26;
    localparam int unsigned OUT_W   = 39;
    localparam int unsigned PROD_W  = IN_W + GAIN_W + 1;
    localparam int unsigned ALIGN_W = PROD_W + 6;
    localparam int unsigned HEAD_W  = ALIGN_W - OUT_W + 1;
    localparam int unsigned ERR_W   = OUT_W + 1;
    localparam int unsigned SUM_W   = GAIN_W + 2;
    localparam int unsigned STEP_SH = 12 + MU_SHIFT;

    logic signed [OUT_W-1:0]   out_q, out_d;
    logic        [GAIN_W-1:0]  gain_q, gain_d;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ALIGN_W-1:0] aligned;
    logic signed [OUT_W-1:0]   sat;
    logic        [OUT_W-1:0]   mag;
    logic signed [ERR_W-1:0]   err;
    logic signed [ERR_W-1:0]   step;
    logic signed [SUM_W-1:0]   gain_sum;
    logic        [GAIN_W-1:0]  gain_clamped;

    // Datapath: gained/saturated sample and next gain, both from pre-edge state
    always_comb begin
        prod    = PROD_W'($signed(inp_agc)) * PROD_W'($signed({1'b0, gain_q}));
        aligned = {prod, 6'b0};

        // Fits in 39 bits only when all headroom bits match the sign
        if (aligned[ALIGN_W-1:OUT_W-1] == {HEAD_W{aligned[ALIGN_W-1]}}) begin
            sat = aligned[OUT_W-1:0];
        end else if (aligned[ALIGN_W-1]) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end

        // Unsigned magnitude keeps |-4.0| = 4.0 exact
        mag      = out_q[OUT_W-1] ? OUT_W'(-out_q) : OUT_W'(out_q);
        err      = $signed({1'b0, REF_LEVEL}) - $signed({1'b0, mag});
        step     = err >>> STEP_SH;
        gain_sum = $signed({2'b00, gain_q}) + SUM_W'(step);

        if (gain_sum < $signed({2'b00, GAIN_MIN})) begin
            gain_clamped = GAIN_MIN;
        end else if (gain_sum > $signed({2'b00, GAIN_MAX})) begin
            gain_clamped = GAIN_MAX;
        end else begin
            gain_clamped = gain_sum[GAIN_W-1:0];
        end

        out_d  = out_q;
        gain_d = gain_q;
        if (clk_enable) begin
            out_d  = sat;
            gain_d = gain_clamped;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            gain_q <= GAIN_INIT;
        end else begin
            out_q  <= out_d;
            gain_q <= gain_d;
        end
    end

    assign out_agc = out_q;

endmodule

// File: tb/tb_agc.sv
// Scoreboard bench for agc: an independent integer model predicts output and gain
// for each edge; a monitor pops and compares after every clock.
module tb_agc;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [12:0] inp_agc;
    logic [38:0] out_agc;

    always #5 clk = ~clk;

    agc dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .inp_agc    (inp_agc),
        .out_agc    (out_agc)
    );

    typedef struct {
        logic [38:0] y;
        logic [25:0] g;
        string       tag;
    } exp_t;

    localparam longint Y_MAX  = (64'sd1 <<< 38) - 64'sd1;
    localparam longint Y_MIN  = -(64'sd1 <<< 38);
    localparam longint REF    = 64'sd1 <<< 36;
    localparam longint G_INIT = 64'sd1 <<< 24;
    localparam longint G_MAX  = (64'sd1 <<< 26) - 64'sd1;

    exp_t   sb[$];
    longint m_y;
    longint m_g;
    int     vectors;
    int     miscompares;

    // Reference model of one enabled edge
    function automatic void model_step(input logic [12:0] x);
        longint p, a, mag, e, d, gn;
        p = longint'($signed(x)) * m_g;
        a = p * 64;
        if (a > Y_MAX) a = Y_MAX;
        if (a < Y_MIN) a = Y_MIN;
        mag = (m_y < 0) ? -m_y : m_y;
        e   = REF - mag;
        d   = e >>> 20;
        gn  = m_g + d;
        if (gn < 0) gn = 0;
        if (gn > G_MAX) gn = G_MAX;
        m_y = a;
        m_g = gn;
    endfunction

    task automatic apply(input logic [12:0] x, input logic en, input string tag);
        exp_t e;
        inp_agc    = x;
        clk_enable = en;
        if (en) model_step(x);
        e.y   = 39'(m_y);
        e.g   = 26'(m_g);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard checker
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (out_agc !== e.y || dut.gain_q !== e.g) begin
                miscompares++;
                $display("FAIL sb_%s: got out_agc=%h gain=%h, expected out_agc=%h gain=%h",
                         e.tag, out_agc, dut.gain_q, e.y, e.g);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if (out_agc !== 39'h0 || dut.gain_q !== 26'h100_0000) begin
            miscompares++;
            $display("FAIL reset_async: got out=%h gain=%h, expected out=0 gain=1000000",
                     out_agc, dut.gain_q);
        end
        for (int i = 0; i < 4; i++) begin
            inp_agc    = 13'($urandom);
            clk_enable = 1'b1;
            @(posedge clk);
            #2;
            vectors++;
            if (out_agc !== 39'h0 || dut.gain_q !== 26'h100_0000) begin
                miscompares++;
                $display("FAIL reset_hold: got out=%h gain=%h, expected out=0 gain=1000000",
                         out_agc, dut.gain_q);
            end
        end
        reset = 1'b0;
        m_y   = 0;
        m_g   = G_INIT;
    endtask

    task automatic test_steady();
        test_reset();
        apply(13'h0040, 1'b1, "steady");
        vectors++;
        if (out_agc !== 39'h10_0000_0000 || dut.gain_q !== 26'h101_0000) begin
            miscompares++;
            $display("FAIL steady_first: got out=%h gain=%h, expected out=1000000000 gain=1010000",
                     out_agc, dut.gain_q);
        end
        apply(13'h0040, 1'b1, "steady");
        vectors++;
        if (out_agc !== 39'h10_1000_0000) begin
            miscompares++;
            $display("FAIL steady_second: got %h, expected 1010000000", out_agc);
        end
        for (int i = 0; i < 60; i++) apply(13'h0040, 1'b1, "steady");
    endtask

    task automatic test_growth();
        test_reset();
        apply(13'h0020, 1'b1, "growth");
        vectors++;
        if (out_agc !== 39'h08_0000_0000) begin
            miscompares++;
            $display("FAIL growth_first: got %h, expected 0800000000", out_agc);
        end
        apply(13'h0020, 1'b1, "growth");
        vectors++;
        if (dut.gain_q !== 26'h101_8000) begin
            miscompares++;
            $display("FAIL growth_gain: got %h, expected 1018000", dut.gain_q);
        end
        for (int i = 0; i < 200; i++) apply(13'h0020, 1'b1, "growth");
    endtask

    task automatic test_attack();
        test_reset();
        apply(13'h1000, 1'b1, "attack");
        vectors++;
        if (out_agc !== 39'h40_0000_0000) begin
            miscompares++;
            $display("FAIL attack_sat: got %h, expected 4000000000", out_agc);
        end
        apply(13'h1000, 1'b1, "attack");
        vectors++;
        if (dut.gain_q !== 26'h0FE_0000) begin
            miscompares++;
            $display("FAIL attack_gain: got %h, expected 0FE0000", dut.gain_q);
        end
        for (int i = 0; i < 300; i++) apply(13'h1000, 1'b1, "attack");
    endtask

    task automatic test_upper_clamp();
        test_reset();
        for (int i = 0; i < 767; i++) apply(13'h0000, 1'b1, "clamp");
        vectors++;
        if (dut.gain_q !== 26'h3FF_0000) begin
            miscompares++;
            $display("FAIL clamp_767: got %h, expected 3FF0000", dut.gain_q);
        end
        for (int i = 0; i < 33; i++) apply(13'h0000, 1'b1, "clamp");
        vectors++;
        if (dut.gain_q !== 26'h3FF_FFFF || out_agc !== 39'h0) begin
            miscompares++;
            $display("FAIL clamp_hold: got gain=%h out=%h, expected gain=3FFFFFF out=0",
                     dut.gain_q, out_agc);
        end
    endtask

    task automatic test_enable_freeze();
        test_reset();
        for (int i = 0; i < 20; i++) apply(13'($urandom), 1'b1, "run");
        for (int i = 0; i < 10; i++) apply(13'($urandom), 1'b0, "frozen");
        for (int i = 0; i < 20; i++) apply(13'($urandom), 1'b1, "resume");
        for (int i = 0; i < 40; i++) apply(13'($urandom), 1'($urandom_range(0, 1)), "mixed");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 15; i++) apply(13'($urandom_range(0, 255)), 1'b1, "pre_reset");
        test_reset();
        apply(13'h0040, 1'b1, "post_reset");
        vectors++;
        if (out_agc !== 39'h10_0000_0000) begin
            miscompares++;
            $display("FAIL post_reset_first: got %h, expected 1000000000", out_agc);
        end
        for (int i = 0; i < 10; i++) apply(13'($urandom), 1'b1, "post_reset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clk_enable  = 1'b0;
        inp_agc     = '0;
        m_y         = 0;
        m_g         = G_INIT;
        #12;
        test_steady();
        test_growth();
        test_attack();
        test_upper_clamp();
        test_enable_freeze();
        test_reset_mid();
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
